// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: keeps the PC, talks to instruction memory with a
// req/ready handshake and hands one registered instruction per cycle to IF/ID.
// A redirect flushes the buffered instruction. A request still in flight is
// drained before the new target is fetched, so the memory never sees its
// address change under a pending request.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPc,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Inst,
  output logic [31:0] PcPlusFour,
  output logic        InstValid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_READY = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] drain_addr_q, drain_addr_d;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  // The add wraps naturally modulo 2^32 (FFFF_FFFC + 4 -> 0).
  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = RedirectPc & ~32'd3;

  // State register, PC, instruction buffer and the address of a request
  // being drained.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC & ~32'd3;
      buf_q        <= 32'h0;
      buf_pc4_q    <= 32'h0;
      drain_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      buf_pc4_q    <= buf_pc4_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // Next-state logic and memory request; Redirect takes priority everywhere.
  // NOTE: every signal gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    buf_pc4_d    = buf_pc4_q;
    drain_addr_d = drain_addr_q;
    mem_req      = 1'b0;
    mem_addr     = pc_q;

    unique case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (Redirect) begin
          pc_d      = redirect_pc;
          buf_d     = 32'h0;
          buf_pc4_d = 32'h0;
          if (IMemReady) begin
            // Returned word belongs to the old path: drop it.
            state_d = S_FETCH;
          end else begin
            // Keep presenting the old address until memory answers.
            drain_addr_d = pc_q;
            state_d      = S_DRAIN;
          end
        end else if (IMemReady) begin
          buf_d     = IMemData;
          buf_pc4_d = pc_plus4;
          pc_d      = pc_plus4;
          state_d   = S_READY;
        end
      end

      S_READY: begin
        if (Redirect) begin
          // No new request is issued, so nothing is left in flight.
          pc_d      = redirect_pc;
          buf_d     = 32'h0;
          buf_pc4_d = 32'h0;
          state_d   = S_FETCH;
        end else if (!Stall) begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
          if (IMemReady) begin
            buf_d     = IMemData;
            buf_pc4_d = pc_plus4;
            pc_d      = pc_plus4;
          end else begin
            // PC is unchanged, so FETCH keeps the same address presented.
            state_d = S_FETCH;
          end
        end
      end

      S_DRAIN: begin
        mem_req  = 1'b1;
        mem_addr = drain_addr_q;
        if (Redirect) begin
          pc_d = redirect_pc;
        end
        if (IMemReady) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign IMemReq    = mem_req & ~reset;
  assign IMemAddr   = mem_addr;
  assign InstValid  = (state_q == S_READY) && !reset;
  assign Inst       = InstValid ? buf_q : 32'h0;
  assign PcPlusFour = InstValid ? buf_pc4_q : 32'h0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a table of per-cycle stimulus and
// expected outputs, followed by hand-written redirect/reset corner sequences.
// The memory model returns the requested address as the instruction word.
module tb_if_fetch_stage;

  logic        clock;
  logic        reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPc;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] Inst;
  logic [31:0] PcPlusFour;
  logic        InstValid;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock      (clock),
    .reset      (reset),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPc (RedirectPc),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemReady  (IMemReady),
    .IMemData   (IMemData),
    .Inst       (Inst),
    .PcPlusFour (PcPlusFour),
    .InstValid  (InstValid)
  );

  // Clock starts high so the first negedge (check point) precedes the first
  // posedge (state update).
  initial clock = 1'b1;
  always #5 clock = ~clock;

  assign IMemData = IMemAddr;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic stall, logic redir,
                              logic [31:0] rpc, logic rdy, logic e_req,
                              logic [31:0] e_addr, logic e_valid,
                              logic [31:0] e_inst, logic [31:0] e_pc4);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_inst = e_inst; v.e_pc4 = e_pc4;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs at the negedge, then let the
  // posedge commit the cycle.
  task automatic run_vec(input vec_t v, input string tag);
    reset      = v.rst;
    Stall      = v.stall;
    Redirect   = v.redir;
    RedirectPc = v.rpc;
    IMemReady  = v.rdy;
    @(negedge clock);
    check({tag, " IMemReq"},    {31'h0, IMemReq},   {31'h0, v.e_req});
    check({tag, " InstValid"},  {31'h0, InstValid}, {31'h0, v.e_valid});
    check({tag, " Inst"},       Inst,               v.e_inst);
    check({tag, " PcPlusFour"}, PcPlusFour,         v.e_pc4);
    if (v.e_req) check({tag, " IMemAddr"}, IMemAddr, v.e_addr);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; Redirect = 1'b0;
    RedirectPc = 32'h0; IMemReady = 1'b0;

    //                rst stl red rpc           rdy req addr          vld inst          pc4
    // Reset: nothing requested, nothing valid.
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         32'h0));
    // Zero-wait stream: FETCH then one instruction per cycle.
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h4,         1, 32'h0,         32'h4));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h8,         1, 32'h4,         32'h8));
    // Stall three cycles holding 0x8, no request.
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         32'hC));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         32'hC));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         32'hC));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'hC,         1, 32'h8,         32'hC));
    // Wait states: ready on every third cycle, address held.
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h10,        1, 32'hC,         32'h10));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h10,        0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h10,        0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h14,        1, 32'h10,        32'h14));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h14,        0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h14,        0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h18,        1, 32'h14,        32'h18));
    // Redirect to 0x103 while 0x18 is pending: drain 0x18, Stall ignored.
    vecs.push_back(mk(0, 0, 1, 32'h103,       0, 1, 32'h18,        0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 1, 32'h18,        0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h18,        0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h100,       0, 32'h0,         32'h0));
    // Redirect + Stall in READY towards the top word (low bits dropped).
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFE, 1, 0, 32'h0,         1, 32'h100,       32'h104));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0));
    // PC wraps to 0.
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h0,         1, 32'hFFFF_FFFC, 32'h0));
    // Redirect while a load would happen: load suppressed.
    vecs.push_back(mk(0, 0, 1, 32'h200,       1, 0, 32'h0,         1, 32'h0,         32'h4));
    // Redirect in FETCH with ready: data dropped, refetch at new target.
    vecs.push_back(mk(0, 0, 1, 32'h300,       1, 1, 32'h200,       0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h300,       0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h304,       1, 32'h300,       32'h304));
    // Reset mid-stream.
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0,         0, 32'h0,         32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Repeated redirect in DRAIN only moves the PC; the old address is
    // still presented until memory answers.
    run_vec(mk(0, 0, 1, 32'h40, 0, 1, 32'h0,  0, 32'h0, 32'h0), "drain_enter");
    run_vec(mk(0, 0, 1, 32'h80, 0, 1, 32'h0,  0, 32'h0, 32'h0), "drain_redir");
    run_vec(mk(0, 0, 0, 32'h0,  1, 1, 32'h0,  0, 32'h0, 32'h0), "drain_done");
    run_vec(mk(0, 0, 1, 32'h44, 0, 1, 32'h80, 0, 32'h0, 32'h0), "refetch_80");

    // Reset while draining 0x80: fetch restarts at RESET_PC, and the first
    // valid instruction appears one cycle after reset is released.
    run_vec(mk(1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 32'h0), "rst_in_drain");
    run_vec(mk(0, 0, 0, 32'h0, 1, 1, 32'h0, 0, 32'h0, 32'h0), "post_rst_fetch");
    run_vec(mk(0, 0, 0, 32'h0, 1, 1, 32'h4, 1, 32'h0, 32'h4), "first_valid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Stall  input  1  hazard unit hold; 1 = IF/ID will not capture this cycle.
REQ-005 SHALL have port Redirect  input  1  branch/jump taken; flush and refetch from RedirectPc.
REQ-006 SHALL have port RedirectPc  input  32  target address; bits [1:0] ignored and forced to 0.
REQ-007 SHALL have port IMemReq  output  1  instruction memory request, held until IMemReady.
REQ-008 SHALL have port IMemAddr  output  32  word-aligned fetch address, stable while IMemReq=1 and IMemReady=0.
REQ-009 SHALL have port IMemReady  input  1  memory returns IMemData this cycle for the address presented.
REQ-010 SHALL have port IMemData  input  32  fetched instruction word.
REQ-011 SHALL have port Inst  output  32  instruction to IF/ID; 32'h0 (NOP) whenever InstValid=0.
REQ-012 SHALL have port PcPlusFour  output  32  address of Inst plus 4; 32'h0 whenever InstValid=0.
REQ-013 SHALL have port InstValid  output  1  Inst/PcPlusFour valid; drives IF/ID write enable together with !Stall.

Function
REQ-014 SHALL hold a 32-bit PC register of the next address to fetch; PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-015 SHALL implement states FETCH, READY, DRAIN; Inst/PcPlusFour SHALL come from a registered buffer, never combinationally from IMemData.
REQ-016 FETCH: IMemReq=1, IMemAddr=PC, InstValid=0; on IMemReady: buffer<=IMemData, BufPc4<=PC+4, PC<=PC+4, go READY.
REQ-017 READY with Stall=1: IMemReq=0, buffer and PC held, InstValid=1, stay READY (any number of cycles).
REQ-018 READY with Stall=0: IMemReq=1 at IMemAddr=PC; on IMemReady load new buffer, PC<=PC+4, stay READY (one instruction per cycle with zero-wait memory); without IMemReady go FETCH.
REQ-019 Redirect=1 SHALL have priority over Stall and over all state transitions.
REQ-020 Redirect in READY, or in FETCH with IMemReady=1: PC<=RedirectPc&~3, buffer invalidated, returned data discarded, go FETCH.
REQ-021 Redirect in FETCH with IMemReady=0: PC<=RedirectPc&~3, buffer invalidated, go DRAIN.
REQ-022 DRAIN: IMemReq=1 with the old in-flight address, InstValid=0; on IMemReady discard data, go FETCH; further Redirect in DRAIN SHALL only overwrite PC.
REQ-023 Redirect in the same cycle a buffer would load SHALL suppress that load; InstValid SHALL be 0 the following cycle.
REQ-024 Stall while InstValid=0 SHALL have no effect on FETCH/DRAIN progress.
REQ-025 Latency: with IMemReady tied 1, first InstValid=1 SHALL be the cycle after reset deasserts +1 (FETCH cycle, then READY).

Reset
REQ-026 reset=1 at a posedge SHALL set PC=RESET_PC, state=FETCH, buffer=0, BufPc4=0, regardless of state or other inputs, including mid-DRAIN.
REQ-027 During and after reset until first load: InstValid=0, Inst=0, PcPlusFour=0; IMemReq=0 while reset=1.
REQ-028 Memory responses pending at reset SHALL be the memory's responsibility to abandon (memory shares the reset).

Verification
REQ-029 Zero-wait stream: IMemReady=1, IMemData=addr, Stall=0 -> Inst 0x0,0x4,0x8 on consecutive cycles, PcPlusFour 0x4,0x8,0xC.
REQ-030 Stall: assert Stall 3 cycles while Inst=0x8 -> Inst=0x8, InstValid=1, IMemReq=0 for 3 cycles, then 0xC next.
REQ-031 Wait states: IMemReady every 3rd cycle -> InstValid=0 in wait cycles, IMemAddr stable, no instruction skipped or duplicated.
REQ-032 Redirect during wait: Redirect=1, RedirectPc=0x103 while fetch of 0x10 pending -> IMemAddr stays 0x10 until ready, data discarded, next fetch at 0x100, Inst from 0x100 with PcPlusFour=0x104.
REQ-033 Redirect+Stall same cycle in READY -> InstValid=0 next cycle, then fetch at RedirectPc.
REQ-034 Wrap and reset: Redirect to 0xFFFFFFFC -> PcPlusFour=0x0, next fetch 0x0; reset mid-stream -> next IMemAddr=RESET_PC, InstValid=0.
